// File: rtl/store_buffer_if.sv
// store_buffer_if: bundles the store-issue, load-check and cache-write
// signals of the store buffer.
//
// Signal groups:
//   store issue : st_valid_i, st_ready_o, st_addr_i, st_data_i, st_funct3_i, st_err_o
//   load check  : ld_check_i, ld_addr_i, ld_hazard_o
//   cache write : drain_en_i, we_o, w_addr_o, w_data_o, mem_mode_o
//   status      : count_o, empty_o
//
// Handshake: a store transfers at the rising clock edge where st_valid_i and
// st_ready_o are both high and st_funct3_i is SB/SH/SW. The producer may hold
// st_valid_i high with stable payload while st_ready_o is low. st_ready_o
// depends only on registered state. On the cache side drain_en_i plays the
// role of ready: an entry is written and retired at the edge where we_o is high.
//
// Modports: slave = the store buffer itself, master = pipeline/cache side.
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) ();
  logic              st_valid_i;
  logic              st_ready_o;
  logic [ADDR_W-1:0] st_addr_i;
  logic [DATA_W-1:0] st_data_i;
  logic [2:0]        st_funct3_i;
  logic              st_err_o;

  logic              ld_check_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_hazard_o;

  logic              drain_en_i;
  logic              we_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [DATA_W-1:0] w_data_o;
  logic [2:0]        mem_mode_o;

  logic [CNT_W-1:0]  count_o;
  logic              empty_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_funct3_i,
    input  ld_check_i, ld_addr_i,
    input  drain_en_i,
    output st_ready_o, st_err_o, ld_hazard_o,
    output we_o, w_addr_o, w_data_o, mem_mode_o,
    output count_o, empty_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_funct3_i,
    output ld_check_i, ld_addr_i,
    output drain_en_i,
    input  st_ready_o, st_err_o, ld_hazard_o,
    input  we_o, w_addr_o, w_data_o, mem_mode_o,
    input  count_o, empty_o
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores (SB/SH/SW) between the MEM
// stage and the data cache write port. One entry drains per cycle when the
// cache port is available. Loads whose 4-byte word overlaps any pending
// store's bytes are flagged so the pipeline can hold them.
//
// Ports:
//   clk_i  : clock, all state changes on its rising edge
//   rst_ni : asynchronous active-low reset, discards all pending stores
//   sb     : store_buffer_if.slave (store issue, load check, cache write, status)
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Entry storage. Payload fields are only meaningful while the matching
  // valid bit is set, so they carry no reset.
  logic [ADDR_W-1:0] r_addr   [DEPTH];
  logic [DATA_W-1:0] r_data   [DEPTH];
  logic [2:0]        r_funct3 [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic              w_legal;
  logic              w_ready;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_hazard;
  logic [ADDR_W:0]   w_ld_lo;
  logic [ADDR_W:0]   w_ld_hi;

  // Offset of the last byte touched by a store of the given width.
  function automatic logic [2:0] last_byte_off(input logic [2:0] funct3);
    case (funct3)
      F3_SB:   last_byte_off = 3'd0;
      F3_SH:   last_byte_off = 3'd1;
      default: last_byte_off = 3'd3;
    endcase
  endfunction

  // Upper end of a byte span, one bit wider than the address so a span that
  // runs past the top of memory does not wrap around to low addresses.
  function automatic logic [ADDR_W:0] span_hi(input logic [ADDR_W-1:0] lo,
                                               input logic [2:0]        off);
    span_hi = {1'b0, lo} + {{(ADDR_W - 2){1'b0}}, off};
  endfunction

  assign w_legal = (sb.st_funct3_i == F3_SB) ||
                   (sb.st_funct3_i == F3_SH) ||
                   (sb.st_funct3_i == F3_SW);

  assign w_ready = (r_count < DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = sb.st_valid_i && w_ready && w_legal;
  assign w_pop   = !w_empty && sb.drain_en_i;

  // Loads always read a full word, so their span is [l, l+3].
  assign w_ld_lo = {1'b0, sb.ld_addr_i};
  assign w_ld_hi = span_hi(sb.ld_addr_i, 3'd3);

  // Every valid entry takes part, including the one draining this cycle;
  // a store arriving this cycle is not yet in the array and is ignored.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] &&
          ({1'b0, r_addr[i]} <= w_ld_hi) &&
          (w_ld_lo <= span_hi(r_addr[i], last_byte_off(r_funct3[i])))) begin
        w_hazard = 1'b1;
      end
    end
  end

  // Control state: pointers, occupancy, valid bits, error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= sb.st_valid_i && !w_legal;

      // Head and tail only coincide when empty (no pop) or full (no push),
      // so the two valid-bit updates never target the same entry.
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload capture; entries are never modified after the push.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_tail]   <= sb.st_addr_i;
      r_data[r_tail]   <= sb.st_data_i;
      r_funct3[r_tail] <= sb.st_funct3_i;
    end
  end

  assign sb.st_ready_o  = w_ready;
  assign sb.st_err_o    = r_err;
  assign sb.ld_hazard_o = sb.ld_check_i && w_hazard;

  // Write bus shows the head entry while anything is pending, zero otherwise.
  assign sb.we_o       = w_pop;
  assign sb.w_addr_o   = w_empty ? '0 : r_addr[r_head];
  assign sb.w_data_o   = w_empty ? '0 : r_data[r_head];
  assign sb.mem_mode_o = w_empty ? '0 : r_funct3[r_head];

  assign sb.count_o = r_count;
  assign sb.empty_o = w_empty;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic for store_buffer.
// A reference model keeps the pending stores as a plain queue; accepted stores
// are pushed onto a scoreboard queue and a monitor pops them as cache writes
// appear, while also checking status, error pulse and load hazard each cycle.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;
  localparam int EW     = ADDR_W + DATA_W + 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        f3;
  } ent_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sb     (sb_if.slave)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- reference state / scoreboard ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [EW-1:0]  exp_q[$];
  ent_t           model_q[$];
  logic           err_exp  = 1'b0;

  function automatic bit legal_f3(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
  endfunction

  function automatic longint unsigned store_bytes(input logic [2:0] f);
    case (f)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  // Any pending store sharing a byte with the word [la, la+3]?
  function automatic bit hazard_ref(input logic [ADDR_W-1:0] la);
    longint unsigned s_lo, s_hi, l_lo, l_hi;
    l_lo = longint'(la);
    l_hi = l_lo + 3;
    foreach (model_q[i]) begin
      s_lo = longint'(model_q[i].addr);
      s_hi = s_lo + store_bytes(model_q[i].f3) - 1;
      if (s_lo <= l_hi && l_lo <= s_hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per rising edge from the inputs it saw.
  task automatic model_loop();
    forever begin
      ent_t e;
      bit   do_pop, do_push;
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        model_q.delete();
        exp_q.delete();
        err_exp = 1'b0;
      end else begin
        do_pop  = sb_if.drain_en_i && (model_q.size() != 0);
        do_push = sb_if.st_valid_i && legal_f3(sb_if.st_funct3_i) &&
                  (model_q.size() < DEPTH);
        err_exp = sb_if.st_valid_i && !legal_f3(sb_if.st_funct3_i);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.addr = sb_if.st_addr_i;
          e.data = sb_if.st_data_i;
          e.f3   = sb_if.st_funct3_i;
          model_q.push_back(e);
          exp_q.push_back(EW'(e));
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from state updates.
  task automatic monitor_loop();
    forever begin
      int   n;
      ent_t e;
      @(negedge clk_i);
      n = model_q.size();
      chk("count", 64'(sb_if.count_o), 64'(n));
      chk("empty", 64'(sb_if.empty_o), 64'(n == 0));
      chk("st_ready", 64'(sb_if.st_ready_o), 64'(n < DEPTH));
      chk("st_err", 64'(sb_if.st_err_o), 64'(err_exp));
      chk("we", 64'(sb_if.we_o), 64'(sb_if.drain_en_i && n != 0));
      chk("ld_hazard", 64'(sb_if.ld_hazard_o),
          64'(sb_if.ld_check_i && hazard_ref(sb_if.ld_addr_i)));
      if (sb_if.we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write: unexpected write addr 0x%0h, none pending", sb_if.w_addr_o);
        end else begin
          e = ent_t'(exp_q.pop_front());
          chk("w_addr", 64'(sb_if.w_addr_o), 64'(e.addr));
          chk("w_data", 64'(sb_if.w_data_o), 64'(e.data));
          chk("mem_mode", 64'(sb_if.mem_mode_o), 64'(e.f3));
        end
      end else if (n == 0) begin
        chk("idle_bus", {sb_if.w_addr_o, sb_if.w_data_o}, 64'd0);
        chk("idle_mode", 64'(sb_if.mem_mode_o), 64'd0);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [2:0] f);
    sb_if.st_valid_i  = v;
    sb_if.st_addr_i   = a;
    sb_if.st_data_i   = d;
    sb_if.st_funct3_i = f;
  endtask

  task automatic push1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [2:0] f);
    set_st(1'b1, a, d, f);
    cyc();
    sb_if.st_valid_i = 1'b0;
  endtask

  task automatic drain_all();
    sb_if.drain_en_i = 1'b1;
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      if (model_q.size() == 0) break;
      cyc();
    end
    sb_if.drain_en_i = 1'b0;
    #1;
    chk("drained_empty", 64'(sb_if.empty_o), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    set_st(1'b0, '0, '0, 3'b000);
    sb_if.ld_check_i = 1'b1;
    sb_if.ld_addr_i  = '0;
    sb_if.drain_en_i = 1'b0;

    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset values
    #2;
    chk("rst_count", 64'(sb_if.count_o), 64'd0);
    chk("rst_ready", 64'(sb_if.st_ready_o), 64'd1);
    chk("rst_empty", 64'(sb_if.empty_o), 64'd1);
    chk("rst_we", 64'(sb_if.we_o), 64'd0);
    chk("rst_err", 64'(sb_if.st_err_o), 64'd0);
    chk("rst_hazard", 64'(sb_if.ld_hazard_o), 64'd0);
    sb_if.ld_check_i = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Single SW, then drain it
    push1(32'h100, 32'hDEADBEEF, 3'b010);
    #1;
    chk("sw_count", 64'(sb_if.count_o), 64'd1);
    chk("sw_we_off", 64'(sb_if.we_o), 64'd0);
    sb_if.drain_en_i = 1'b1;
    #1;
    chk("sw_we", 64'(sb_if.we_o), 64'd1);
    chk("sw_addr", 64'(sb_if.w_addr_o), 64'h100);
    chk("sw_data", 64'(sb_if.w_data_o), 64'hDEADBEEF);
    chk("sw_mode", 64'(sb_if.mem_mode_o), 64'd2);
    cyc();
    chk("sw_empty", 64'(sb_if.empty_o), 64'd1);
    chk("sw_we_done", 64'(sb_if.we_o), 64'd0);
    sb_if.drain_en_i = 1'b0;

    // Fill, refuse a fifth, then accept it right after the first pop
    for (int i = 0; i < DEPTH; i++) begin
      set_st(1'b1, 32'h10 + 32'(i), 32'hA1 + 32'(i), 3'b000);
      cyc();
    end
    set_st(1'b1, 32'h14, 32'hA5, 3'b000);
    #1;
    chk("full_ready", 64'(sb_if.st_ready_o), 64'd0);
    chk("full_count", 64'(sb_if.count_o), 64'd4);
    cyc();
    chk("refused_count", 64'(sb_if.count_o), 64'd4);
    sb_if.drain_en_i = 1'b1;
    #1;
    chk("first_pop_addr", 64'(sb_if.w_addr_o), 64'h10);
    cyc();
    chk("after_pop_count", 64'(sb_if.count_o), 64'd3);
    chk("after_pop_ready", 64'(sb_if.st_ready_o), 64'd1);
    chk("second_addr", 64'(sb_if.w_addr_o), 64'h11);
    cyc();
    sb_if.st_valid_i = 1'b0;
    chk("push_pop_count", 64'(sb_if.count_o), 64'd3);
    chk("third_addr", 64'(sb_if.w_addr_o), 64'h12);
    drain_all();

    // Load hazard against a pending SH
    push1(32'h202, 32'h1234, 3'b001);
    sb_if.ld_check_i = 1'b1;
    sb_if.ld_addr_i  = 32'h200;
    #1;
    chk("hz_sh_overlap", 64'(sb_if.ld_hazard_o), 64'd1);
    sb_if.ld_addr_i = 32'h204;
    #1;
    chk("hz_sh_clear", 64'(sb_if.ld_hazard_o), 64'd0);
    sb_if.drain_en_i = 1'b1;
    cyc();
    sb_if.drain_en_i = 1'b0;
    sb_if.ld_addr_i  = 32'h200;
    #1;
    chk("hz_after_drain", 64'(sb_if.ld_hazard_o), 64'd0);

    // Top-of-memory: no wrap to address 0
    push1(32'hFFFF_FFFE, 32'h55, 3'b010);
    sb_if.ld_addr_i = 32'h0;
    #1;
    chk("hz_no_wrap", 64'(sb_if.ld_hazard_o), 64'd0);
    sb_if.ld_addr_i = 32'hFFFF_FFFC;
    #1;
    chk("hz_top", 64'(sb_if.ld_hazard_o), 64'd1);
    sb_if.ld_check_i = 1'b0;
    #1;
    chk("hz_no_check", 64'(sb_if.ld_hazard_o), 64'd0);
    drain_all();

    // Illegal funct3
    set_st(1'b1, 32'h300, 32'h77, 3'b011);
    cyc();
    sb_if.st_valid_i = 1'b0;
    #1;
    chk("err_pulse", 64'(sb_if.st_err_o), 64'd1);
    chk("err_count", 64'(sb_if.count_o), 64'd0);
    cyc();
    chk("err_gone", 64'(sb_if.st_err_o), 64'd0);

    // Reset in the middle of draining
    push1(32'h400, 32'h1, 3'b010);
    push1(32'h404, 32'h2, 3'b010);
    push1(32'h408, 32'h3, 3'b010);
    sb_if.drain_en_i = 1'b1;
    cyc();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_we", 64'(sb_if.we_o), 64'd0);
    chk("midrst_count", 64'(sb_if.count_o), 64'd0);
    chk("midrst_ready", 64'(sb_if.st_ready_o), 64'd1);
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("no_stale_we", 64'(sb_if.we_o), 64'd0);
    end
    sb_if.drain_en_i = 1'b0;

    // Randomized traffic; drain probability changes by phase to reach full
    for (int i = 0; i < 2000; i++) begin
      logic [ADDR_W-1:0] a;
      logic [2:0]        f;
      int                phase;
      phase = (i / 200) % 3;
      f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                      : 32'h40 + $urandom_range(0, 31);
      set_st(1'($urandom_range(0, 1)), a, $urandom, f);
      case (phase)
        0:       sb_if.drain_en_i = ($urandom_range(0, 3) != 0);
        1:       sb_if.drain_en_i = ($urandom_range(0, 3) == 0);
        default: sb_if.drain_en_i = 1'($urandom_range(0, 1));
      endcase
      sb_if.ld_check_i = 1'($urandom_range(0, 1));
      sb_if.ld_addr_i  = ($urandom_range(0, 7) == 0)
                         ? (($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                        : 32'($urandom_range(0, 3)))
                         : 32'h3C + $urandom_range(0, 40);
      cyc();
    end
    sb_if.st_valid_i = 1'b0;
    sb_if.ld_check_i = 1'b0;
    drain_all();
    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM pipeline stage and the data cache write port.
- Accepts committed stores (SB/SH/SW) into a small in-order FIFO and drains one entry per cycle into the cache write interface (we/w_addr/w_data/mem_mode).
- Flags loads whose bytes overlap any pending store, so the pipeline stalls the load until the conflicting stores have drained.
- Decouples store issue from cache write timing and adds the sequential ordering the cache itself lacks.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
ADDR_W, 32, address width (matches SYS_ADDR_SPACE)
DATA_W, 32, data width (matches DATA_WIDTH)

Ports:
clk_i  in  1  clock; all state updates on its rising edge
rst_ni  in  1  asynchronous, active-low reset
st_valid_i  in  1  store request valid
st_ready_o  out  1  buffer can accept a store
st_addr_i  in  ADDR_W  store byte address
st_data_i  in  DATA_W  store data, right-aligned
st_funct3_i  in  3  SB=000, SH=001, SW=010
st_err_o  out  1  one-cycle pulse: illegal funct3 presented
ld_check_i  in  1  a load is being issued this cycle
ld_addr_i  in  ADDR_W  load byte address
ld_hazard_o  out  1  load overlaps a pending store; hold the load
drain_en_i  in  1  cache write port available this cycle
we_o  out  1  cache write enable
w_addr_o  out  ADDR_W  cache write address
w_data_o  out  DATA_W  cache write data
mem_mode_o  out  3  cache write funct3
count_o  out  clog2(DEPTH)+1  number of occupied entries
empty_o  out  1  count_o == 0

Behaviour:
- Reset (async, rst_ni=0):
  - Head pointer, tail pointer and count clear to 0; all entry valid bits clear to 0.
  - Outputs immediately: we_o=0, st_ready_o=1, empty_o=1, count_o=0, st_err_o=0, ld_hazard_o=0.
  - Data, address and mode outputs are 0 while empty.
  - Reset mid-drain discards every pending store, and we_o drops within the same cycle.
- Entry fields: addr, data, funct3, valid.
- Accepting stores:
  - st_ready_o = (count_o < DEPTH). It is registered-state-only; there is no combinational path from drain_en_i.
  - A push occurs when st_valid_i && st_ready_o && funct3 is legal.
  - Illegal funct3 with st_valid_i=1: nothing is enqueued; st_err_o pulses high for the following cycle (registered).
- Drain (combinational from state):
  - we_o = !empty && drain_en_i.
  - w_addr_o, w_data_o and mem_mode_o show the head entry whenever the buffer is not empty.
  - A pop occurs at the clock edge when we_o=1. Each entry is written exactly once, in FIFO order.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: pushes are refused (st_ready_o=0). A pop in that cycle makes st_ready_o=1 in the next cycle.
- Pointers wrap modulo DEPTH.
- Store byte span: [a, a+s-1], with s=1/2/4 for SB/SH/SW.
- Load span: [l, l+3]. It is always treated as 4 bytes, because the cache reads a full word.
- Overlap test: a_lo <= b_hi && b_lo <= a_hi, computed in ADDR_W+1 bits so there is no wrap at 0xFFFFFFFF.
- Hazard:
  - ld_hazard_o = ld_check_i && OR over valid entries of overlap. It is combinational.
  - The entry being popped this cycle still counts.
  - A store being pushed in the same cycle is not checked. The pipeline orders a store ahead of a younger load by at least one cycle.
- No merging or coalescing of entries; the bytes of an entry are never modified after push.
- count_o is always in 0..DEPTH; empty_o is 1 exactly when count_o=0.

Test Plan:
- Reset, then push SW addr 0x100 data 0xDEADBEEF with drain_en_i=0 -> count_o=1, we_o=0. Raise drain_en_i -> one cycle of we_o=1 with w_addr_o=0x100, w_data_o=0xDEADBEEF, mode_o=010; then empty_o=1.
- Fill with DEPTH=4 stores (SB 0x10/0x11/0x12/0x13, data 0xA1..0xA4) with drain off -> st_ready_o=0 after the 4th; a 5th push is refused.
  - Enable drain while st_valid_i=1 -> writes appear in the order 0x10..0x13, and the 5th store is accepted in the cycle after the first pop.
- Pending SH at 0x202; load check at 0x200 -> ld_hazard_o=1 (bytes 0x200-0x203 overlap 0x202-0x203).
  - Load at 0x204 -> ld_hazard_o=0.
  - After the SH drains, load at 0x200 -> ld_hazard_o=0.
- Edge cases:
  - SW at 0xFFFFFFFE pending, load at 0x00000000 -> ld_hazard_o=0 (no wrap).
  - Load at 0xFFFFFFFC -> ld_hazard_o=1.
- st_valid_i=1 with funct3=011 -> no enqueue, count unchanged, st_err_o=1 for exactly one cycle.
- Push 3 stores, drain 1, then assert rst_ni=0 mid-cycle -> we_o=0, count_o=0 and st_ready_o=1 immediately. After release, no stale write ever appears on we_o.
